// File: rtl/uart_transmitter_if.sv
// UART transmitter bus interface.
// Bundles the transmit request/data and the serial line/status signals.
//   i_tick      16x-baud oversampling enable, one clock wide
//   i_tx_start  request to send i_tx_data
//   i_tx_data   frame payload, sent LSB first
//   o_tx        serial line, idle high
//   o_tx_busy   frame in progress
//   o_tx_done   one-cycle pulse at frame completion
// master: the side issuing requests; slave: the transmitter.
interface uart_transmitter_if #(
    parameter int NB_DATA = 8
);
    logic               i_tick;
    logic               i_tx_start;
    logic [NB_DATA-1:0] i_tx_data;
    logic               o_tx;
    logic               o_tx_busy;
    logic               o_tx_done;

    modport master (
        output i_tick, i_tx_start, i_tx_data,
        input  o_tx, o_tx_busy, o_tx_done
    );

    modport slave (
        input  i_tick, i_tx_start, i_tx_data,
        output o_tx, o_tx_busy, o_tx_done
    );
endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, NB_DATA data bits LSB first, optional parity
// bit, and SB_TICK/16 stop bits, paced by a 16x-baud tick enable.
// Ports:
//   i_clock  system clock, rising edge
//   i_reset  asynchronous active-low reset
//   bus      uart_transmitter_if.slave (tick, start, data in; tx, busy, done out)
//
// state     | meaning
// ----------+----------------------------------------------
// ST_IDLE   | line high, waiting for i_tx_start
// ST_START  | start bit (low) for 16 ticks
// ST_DATA   | data bits, LSB of shift register, 16 ticks each
// ST_PARITY | parity bit for 16 ticks (only when PARITY != 0)
// ST_STOP   | stop bit(s), line high for SB_TICK ticks
module uart_transmitter #(
    parameter int NB_DATA = 8,
    parameter int SB_TICK = 16,
    parameter int PARITY  = 0
) (
    input  logic                i_clock,
    input  logic                i_reset,
    uart_transmitter_if.slave   bus
);

    localparam int IDX_W  = $clog2(NB_DATA);
    localparam int STOP_W = $clog2(SB_TICK) + 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NB_DATA - 1);
    localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(SB_TICK - 1);

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_START  = 5'b00010,
        ST_DATA   = 5'b00100,
        ST_PARITY = 5'b01000,
        ST_STOP   = 5'b10000
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         tick_q, tick_d;
    logic [STOP_W-1:0]  stop_q, stop_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NB_DATA-1:0] shreg_q, shreg_d;
    logic               par_q, par_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               bit_end;

    // A bit period closes on the tick that sees the counter at 15.
    assign bit_end = bus.i_tick && (tick_q == 4'd15);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        stop_d  = stop_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_tx_start) begin
                    shreg_d = bus.i_tx_data;
                    // Parity is taken at acceptance since the shift register is consumed.
                    par_d   = (PARITY == 2) ? ~^bus.i_tx_data : ^bus.i_tx_data;
                    tick_d  = 4'd0;
                    idx_d   = '0;
                    stop_d  = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bus.i_tick) begin
                    tick_d = tick_q + 4'd1;
                    if (bit_end) begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (bus.i_tick) begin
                    tick_d = tick_q + 4'd1;
                    if (bit_end) begin
                        shreg_d = shreg_q >> 1;
                        if (idx_q == LAST_IDX) begin
                            idx_d   = '0;
                            state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
            end
            ST_PARITY: begin
                if (bus.i_tick) begin
                    tick_d = tick_q + 4'd1;
                    if (bit_end) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (bus.i_tick) begin
                    if (stop_q == STOP_LAST) begin
                        stop_d  = '0;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tick_d  = 4'd0;
                stop_d  = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Line level is derived from the next state so o_tx can be registered
    // without adding a cycle of latency.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            tick_q  <= 4'd0;
            stop_q  <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            stop_q  <= stop_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.o_tx      = tx_q;
    assign bus.o_tx_busy = busy_q;
    assign bus.o_tx_done = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Testbench for uart_transmitter: three instances (no parity, even parity,
// odd parity with two stop bits) share tick/data/reset; each has its own
// start. A per-instance line decoder compares finished frames against a
// scoreboard queue filled by the stimulus.
module tb_uart_transmitter;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic [2:0] start;
    logic [7:0] tx_data;
    int         tick_div;
    int         tdiv_cnt;
    int         cyc;
    int         n_vec;
    int         n_err;

    logic tx_w   [3];
    logic busy_w [3];
    logic done_w [3];

    typedef struct {
        int         id;
        logic [7:0] data;
        logic       par;
        int         dur;
    } exp_t;

    exp_t sb_q[$];

    uart_transmitter_if #(.NB_DATA(8)) if0 ();
    uart_transmitter_if #(.NB_DATA(8)) if1 ();
    uart_transmitter_if #(.NB_DATA(8)) if2 ();

    assign if0.i_tick = tick;
    assign if1.i_tick = tick;
    assign if2.i_tick = tick;
    assign if0.i_tx_start = start[0];
    assign if1.i_tx_start = start[1];
    assign if2.i_tx_start = start[2];
    assign if0.i_tx_data = tx_data;
    assign if1.i_tx_data = tx_data;
    assign if2.i_tx_data = tx_data;

    assign tx_w[0] = if0.o_tx;
    assign tx_w[1] = if1.o_tx;
    assign tx_w[2] = if2.o_tx;
    assign busy_w[0] = if0.o_tx_busy;
    assign busy_w[1] = if1.o_tx_busy;
    assign busy_w[2] = if2.o_tx_busy;
    assign done_w[0] = if0.o_tx_done;
    assign done_w[1] = if1.o_tx_done;
    assign done_w[2] = if2.o_tx_done;

    uart_transmitter #(.NB_DATA(8), .SB_TICK(16), .PARITY(0)) u_dut0 (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (if0)
    );

    uart_transmitter #(.NB_DATA(8), .SB_TICK(16), .PARITY(1)) u_dut1 (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (if1)
    );

    uart_transmitter #(.NB_DATA(8), .SB_TICK(32), .PARITY(2)) u_dut2 (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (if2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Tick changes shortly after the rising edge, so it is stable at both
    // the following falling edge and the next rising edge.
    initial begin
        tick     = 1'b1;
        tdiv_cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            tdiv_cnt = (tdiv_cnt + 1) % tick_div;
            tick     = (tdiv_cnt == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Caller is at a falling edge; the request is taken at the next rising edge.
    task automatic send(input int id, input logic [7:0] data, input bit push, input int dur);
        exp_t e;
        start[id] = 1'b1;
        tx_data   = data;
        if (push) begin
            e.id   = id;
            e.data = data;
            e.par  = (id == 1) ? ^data : ((id == 2) ? ~^data : 1'b0);
            e.dur  = dur;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        chk("accept_busy", 32'(busy_w[id]), 32'd1);
        chk("accept_tx_low", 32'(tx_w[id]), 32'd0);
        @(negedge clk);
        start[id] = 1'b0;
    endtask

    // Returns at the falling edge where o_tx_done is seen high.
    task automatic wait_done(input int id);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (done_w[id] === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_timeout", 32'(seen), 32'd1);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_mon
        localparam int NBITS = (g == 0) ? 9 : 10;
        localparam int SB    = (g == 2) ? 32 : 16;
        initial begin
            int         n;
            int         last_n;
            int         k;
            int         t0;
            logic [7:0] d;
            logic       p;
            bit         abort;
            exp_t       e;
            @(negedge clk);
            forever begin
                while (!(rst_n === 1'b1 && tx_w[g] === 1'b0)) @(negedge clk);
                t0 = cyc;
                chk("busy_at_start", 32'(busy_w[g]), 32'd1);
                n      = 0;
                last_n = -1;
                abort  = 1'b0;
                d      = 8'h00;
                p      = 1'b0;
                while (n < NBITS * 16 + SB && !abort) begin
                    @(posedge clk);
                    if (tick) n++;
                    @(negedge clk);
                    if (rst_n !== 1'b1) begin
                        abort = 1'b1;
                    end else if ((n % 16) == 8 && n != last_n) begin
                        last_n = n;
                        k = n / 16;
                        if (k == 0) chk("start_bit", 32'(tx_w[g]), 32'd0);
                        else if (k <= 8) d[k-1] = tx_w[g];
                        else if (k < NBITS) p = tx_w[g];
                        else if (k == NBITS) chk("stop_bit", 32'(tx_w[g]), 32'd1);
                    end
                end
                if (abort) begin
                    while (rst_n !== 1'b1) @(negedge clk);
                end else begin
                    chk("done_at_end", 32'(done_w[g]), 32'd1);
                    chk("busy_at_end", 32'(busy_w[g]), 32'd0);
                    chk("tx_at_end", 32'(tx_w[g]), 32'd1);
                    if (sb_q.size() == 0) begin
                        chk("frame_expected", 32'(sb_q.size()), 32'd1);
                    end else begin
                        e = sb_q.pop_front();
                        chk("frame_dut", 32'(g), 32'(e.id));
                        chk("frame_data", 32'(d), 32'(e.data));
                        if (g != 0) chk("frame_parity", 32'(p), 32'(e.par));
                        if (e.dur != 0) chk("frame_cycles", 32'(cyc - t0), 32'(e.dur));
                    end
                    @(negedge clk);
                    chk("done_one_cycle", 32'(done_w[g]), 32'd0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        n_vec    = 0;
        n_err    = 0;
        cyc      = 0;
        tick_div = 1;
        rst_n    = 1'b0;
        start    = 3'b000;
        tx_data  = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_tx0", 32'(tx_w[0]), 32'd1);
        chk("rst_busy0", 32'(busy_w[0]), 32'd0);
        chk("rst_done0", 32'(done_w[0]), 32'd0);
        chk("rst_tx1", 32'(tx_w[1]), 32'd1);
        chk("rst_tx2", 32'(tx_w[2]), 32'd1);

        // First request right at reset release; exact frame length 160.
        rst_n = 1'b1;
        send(0, 8'h55, 1'b1, 160);
        wait_done(0);
        repeat (5) @(negedge clk);

        // Parity variants, one instance at a time.
        send(1, 8'h07, 1'b1, 176);
        wait_done(1);
        repeat (3) @(negedge clk);
        send(2, 8'h07, 1'b1, 192);
        wait_done(2);
        repeat (3) @(negedge clk);
        send(1, 8'h5B, 1'b1, 176);
        wait_done(1);
        repeat (3) @(negedge clk);

        // Slow tick: one every 4 cycles, start bit must last 64 cycles.
        tick_div = 4;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (tick) break;
        end
        send(0, 8'hA3, 1'b1, 0);
        cnt = 1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (tx_w[0] === 1'b0) cnt++;
            else break;
        end
        chk("slow_start_len", 32'(cnt), 32'd64);
        wait_done(0);
        @(negedge clk);
        tick_div = 1;
        repeat (5) @(negedge clk);

        // Start pulsed mid-frame with new data must be ignored.
        send(0, 8'h00, 1'b1, 160);
        repeat (40) @(negedge clk);
        start[0] = 1'b1;
        tx_data  = 8'hFF;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0);
        repeat (200) @(negedge clk);
        chk("no_second_frame_busy", 32'(busy_w[0]), 32'd0);
        chk("no_second_frame_tx", 32'(tx_w[0]), 32'd1);

        // Back-to-back: second request in the done cycle.
        send(0, 8'h12, 1'b1, 160);
        wait_done(0);
        send(0, 8'h34, 1'b1, 160);
        wait_done(0);
        repeat (5) @(negedge clk);

        // Reset during data bit 3 aborts the frame asynchronously.
        send(0, 8'hC6, 1'b0, 0);
        repeat (70) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_tx", 32'(tx_w[0]), 32'd1);
        chk("abort_busy", 32'(busy_w[0]), 32'd0);
        chk("abort_done", 32'(done_w[0]), 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_done_hold", 32'(done_w[0]), 32'd0);
        rst_n = 1'b1;
        send(0, 8'h81, 1'b1, 160);
        wait_done(0);

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
